// File: rtl/pc_unit_ras_pkg.sv
// pc_unit_ras_pkg: shared defaults and next-PC source select for pc_unit_ras
package pc_unit_ras_pkg;
    localparam int          DEF_XLEN        = 64;
    localparam logic [63:0] DEF_RESET_PC    = 64'h0;
    localparam int          DEF_INSTR_BYTES = 4;
    localparam int          DEF_RAS_DEPTH   = 4;
    typedef enum logic [2:0] {SEL_TRAP, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ} pc_sel_e;
endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack with saturating count
// Ports: clk, reset (sync, active-low), enable (allow push/pop), clear (count to 0),
//        push/pop/push_data (call/return requests), top (entry at pointer), empty, full
module ras_stack #(
    parameter int XLEN      = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(RAS_DEPTH);
    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW:0]     count;
    assign top   = mem[ptr];
    assign empty = count == '0;
    assign full  = count == FULL_CNT;
    // ptr always addresses the newest entry; wrapping lets a push on a full
    // stack silently overwrite the oldest one
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (push && pop && !empty) begin
                mem[ptr] <= push_data;
            end else if (push) begin
                ptr              <= ptr + 1'b1;
                mem[ptr + 1'b1]  <= push_data;
                count            <= full ? count : count + 1'b1;
            end else if (pop && !empty) begin
                ptr   <= ptr - 1'b1;
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch PC register with trap/redirect/stall priority and RAS return prediction
// Ports: clk, reset (sync, active-low), pc_write (0 = stall), trap_valid/trap_target,
//        redirect_valid/redirect_target, ras_push/ras_push_addr, ras_pop,
//        pc_out (registered PC), pc_next (combinational next PC), ras_empty, ras_full
module pc_unit_ras
    import pc_unit_ras_pkg::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
    parameter int              INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int              RAS_DEPTH   = DEF_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            ras_empty,
    output logic            ras_full
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);
    logic [XLEN-1:0] ras_top, pc_raw;
    pc_sel_e         sel;
    // flushes beat a stall so a trap or mispredict is never lost
    always_comb begin
        sel    = trap_valid ? SEL_TRAP : redirect_valid ? SEL_REDIR : !pc_write ? SEL_HOLD :
                 (ras_pop && !ras_empty) ? SEL_RAS : SEL_SEQ;
        pc_raw = sel == SEL_TRAP  ? trap_target :
                 sel == SEL_REDIR ? redirect_target :
                 sel == SEL_HOLD  ? pc_out :
                 sel == SEL_RAS   ? ras_top : pc_out + XLEN'(INSTR_BYTES);
    end
    assign pc_next = pc_raw & ALIGN_MASK;
    always_ff @(posedge clk) begin
        if (!reset) pc_out <= RESET_PC;
        else        pc_out <= pc_next;
    end
    ras_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .enable    (pc_write && !trap_valid && !redirect_valid),
        .clear     (trap_valid),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ras_push_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: scoreboard bench for pc_unit_ras against a queue-based reference model
module tb_pc_unit_ras;
    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] MASK   = ~64'h3;
    typedef struct {
        logic [63:0] pc;
        logic        empty;
        logic        full;
    } exp_t;
    logic        clk = 0, reset = 0, pc_write = 0, trap_valid = 0, redirect_valid = 0;
    logic        ras_push = 0, ras_pop = 0;
    logic [63:0] trap_target = 0, redirect_target = 0, ras_push_addr = 0;
    logic [63:0] pc_out, pc_next;
    logic        ras_empty, ras_full;
    int          n_cmp = 0, n_bad = 0;
    exp_t        exp_q[$];
    logic [63:0] ras[$];
    logic [63:0] mpc;
    bit          mvalid = 0;
    pc_unit_ras #(.XLEN(64), .RESET_PC(RST_PC), .INSTR_BYTES(4), .RAS_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_write        (pc_write),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ras_push        (ras_push),
        .ras_push_addr   (ras_push_addr),
        .ras_pop         (ras_pop),
        .pc_out          (pc_out),
        .pc_next         (pc_next),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // one fetch cycle: drive inputs, predict, update the abstract model, queue the expectation
    task automatic step(input bit r, input bit pw, input bit tv, input bit rv, input bit pu,
                        input bit po, input logic [63:0] tt, input logic [63:0] rt,
                        input logic [63:0] pa);
        logic [63:0] nxt;
        @(negedge clk);
        reset = r; pc_write = pw; trap_valid = tv; redirect_valid = rv;
        ras_push = pu; ras_pop = po; trap_target = tt; redirect_target = rt; ras_push_addr = pa;
        #1;
        nxt = tv ? tt : rv ? rt : !pw ? mpc : (po && ras.size() > 0) ? ras[ras.size()-1] : mpc + 64'd4;
        nxt &= MASK;
        if (r && mvalid) chk("pc_next", pc_next, nxt);
        if (!r) begin
            mpc = RST_PC;
            ras.delete();
            mvalid = 1;
        end else begin
            mpc = nxt;
            if (tv) ras.delete();
            else if (pw && !rv) begin
                if (pu && po && ras.size() > 0) ras[ras.size()-1] = pa;
                else if (pu) begin
                    ras.push_back(pa);
                    if (ras.size() > DEPTH) void'(ras.pop_front());
                end else if (po && ras.size() > 0) void'(ras.pop_back());
            end
        end
        exp_q.push_back('{pc: mpc, empty: ras.size() == 0, full: ras.size() == DEPTH});
    endtask
    task automatic idle(input int n);
        repeat (n) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [63:0] a);
        step(1, 1, 0, 0, 1, 0, 0, 0, a);
    endtask
    task automatic pop();
        step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    endtask
    task automatic redir(input bit pw, input logic [63:0] t);
        step(1, pw, 0, 1, 0, 0, 0, t, 0);
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("ras_empty", 64'(ras_empty), 64'(e.empty));
                chk("ras_full", 64'(ras_full), 64'(e.full));
            end
        end
    end
    initial begin : driver
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 1, 0, 0, 0, 64'h500);
        idle(1);
        redir(1, 64'h2000);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        redir(0, 64'h3002);
        push(64'h104);
        push(64'h208);
        pop();
        pop();
        pop();
        push(64'h700);
        step(1, 1, 1, 1, 0, 1, 64'h8000, 64'h4000, 0);
        pop();
        for (int i = 1; i <= 5; i++) push(64'(i * 16));
        repeat (5) pop();
        push(64'h40);
        step(1, 1, 0, 0, 1, 1, 0, 0, 64'h90);
        step(1, 0, 0, 0, 1, 1, 0, 0, 64'hA0);
        pop();
        pop();
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 {$urandom, $urandom}, {$urandom, $urandom}, a);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised next-generation program counter for the 5-stage pipeline. It holds the fetch PC, applies stall (pc_write) and redirect/trap priority, and predicts return targets with a small circular return-address stack (RAS). It sits in IF, feeding instruction memory and the IF/ID register. Redirects come from EX branch resolution and traps come from the hazard/exception logic.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 0, PC value loaded on reset
INSTR_BYTES, 4, sequential increment; power of two, at least 2
RAS_DEPTH, 4, RAS entries; power of two, at least 2

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low; 0 at a rising edge resets the block
pc_write  input  1  1 = advance/update; 0 = stall (hold PC, freeze RAS)
trap_valid  input  1  trap/exception redirect request
trap_target  input  XLEN  trap vector
redirect_valid  input  1  EX-resolved taken branch/jump or mispredict correction
redirect_target  input  XLEN  corrected fetch address
ras_push  input  1  call decoded; push ras_push_addr
ras_push_addr  input  XLEN  return address (call PC + INSTR_BYTES)
ras_pop  input  1  return decoded; fetch from RAS top
pc_out  output  XLEN  registered current fetch PC
pc_next  output  XLEN  combinational next PC, for memory prefetch
ras_empty  output  1  RAS count == 0
ras_full  output  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (reset==0 at the edge): pc_out=RESET_PC; RAS count=0; top pointer=0. Entries are not cleared. Reset wins over every other input.
- Reset outputs: ras_empty=1, ras_full=0. pc_next follows the priority rules below.
- pc_next priority, highest first:
  1) trap_valid: trap_target
  2) redirect_valid: redirect_target
  3) !pc_write: pc_out
  4) ras_pop && !ras_empty: RAS top
  5) otherwise: pc_out + INSTR_BYTES, wrapping modulo 2^XLEN
- Trap and redirect override a stall, because a flush must not be lost.
- Every selected target has its low log2(INSTR_BYTES) bits forced to 0.
- pc_out <= pc_next every cycle; latency is one clock from inputs to pc_out.
- RAS updates occur only when pc_write==1 and neither trap_valid nor redirect_valid is asserted. Otherwise the RAS holds, except that a trap clears the count to 0.
- Push only: ptr+=1 modulo RAS_DEPTH, then write the entry. count saturates at RAS_DEPTH; when full, the oldest entry is silently overwritten.
- Pop only: if count>0, ptr-=1 and count-=1. If count==0, no change and sequential fetch is used.
- Push and pop in the same cycle: pc_next uses the old top. The top entry is then overwritten with ras_push_addr; ptr and count are unchanged. When count==0, this acts as a plain push.
- Redirect does not repair the RAS. Speculative push/pop damage is accepted.
- Mid-operation reset discards all RAS content logically (count=0).

Decomposition:
- Shared package holds XLEN, RESET_PC, INSTR_BYTES and a pc_sel enum (TRAP, REDIR, HOLD, RAS, SEQ) used by the next-PC mux and the assertions.
- One sub-module is natural: ras_stack. It takes the RAS_DEPTH/XLEN parameters plus push, pop, push_data, enable and clear, and outputs top, empty and full. The PC register and priority mux stay in pc_unit_ras.

Test Plan:
- Reset then free run (RESET_PC=0x1000): after reset=1, pc_out goes 0x1000, 0x1004, 0x1008. Assert reset=0 mid-run: pc_out=0x1000 next edge, ras_empty=1.
- Stall vs redirect: pc_out=0x2000, pc_write=0 for 3 cycles: pc_out holds 0x2000. Then pc_write=0 with redirect_valid=1, target 0x3002: pc_out=0x3000 next edge.
- Priority: trap_valid=1 (target 0x8000) with redirect_valid=1 (target 0x4000) and ras_pop=1: pc_out=0x8000, and RAS count becomes 0.
- Call/return: push 0x104, then push 0x208; pop gives pc_out=0x208, next pop gives 0x104. A pop on the empty RAS gives sequential PC.
- Overflow (RAS_DEPTH=4): push 0x10, 0x20, 0x30, 0x40, 0x50: ras_full=1. Four pops return 0x50, 0x40, 0x30, 0x20, then ras_empty=1.
- Simultaneous push+pop with top=0x40: pc_out=0x40 and the top becomes ras_push_addr (0x90), count unchanged. Repeat under pc_write=0: no RAS or PC change.
